stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Stopwatch time-keeping core that sits directly downstream of the clock-divider block. It consumes the 1 Hz and 2 Hz strobes and keeps a BCD minutes:seconds count for the display stage. The count covers 00:00 to MAX_MIN:59. An adjust mode uses the 2 Hz strobe to step the minutes or seconds field manually.

## Interface
Parameters:
- MAX_MIN, 59: highest minutes value; legal range 1..99.

Ports:
- clk  in  1  master clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_1_in  in  1  1 Hz strobe from the divider. It is a level that may stay high for many clk cycles. Only its rising edge is used.
- tick_2_in  in  1  2 Hz strobe from the divider; same level semantics as tick_1_in.
- adj  in  1  adjust-mode request (already debounced and synchronised).
- sel  in  1  adjust field select: 0 = minutes, 1 = seconds.
- clr  in  1  synchronous clear (already debounced), level-sensitive.
- min_tens  out  4  BCD minutes tens digit.
- min_ones  out  4  BCD minutes ones digit.
- sec_tens  out  4  BCD seconds tens digit, 0..5.
- sec_ones  out  4  BCD seconds ones digit.
- mode  out  2  current state: 00 RUN, 01 ADJ_MIN, 10 ADJ_SEC. 11 is never produced.
- wrap  out  1  one-cycle pulse when the RUN count rolls over from MAX_MIN:59 to 00:00.

## Operation
- Edge detect: registers t1_q and t2_q hold the previous samples.
  - p1 = tick_1_in & ~t1_q.
  - p2 = tick_2_in & ~t2_q.
- State machine, registered and updated every clk edge from adj and sel:
  - adj=0 -> RUN.
  - adj=1, sel=0 -> ADJ_MIN.
  - adj=1, sel=1 -> ADJ_SEC.
  - Any state can move directly to any other state.
- Priority order at each edge:
  1. clr=1: all digits go to 0 and wrap=0. The state still updates from adj/sel.
  2. RUN with p1: increment seconds.
     - sec_ones 9 -> 0 carries into sec_tens.
     - sec_tens 5 (with sec_ones 9) -> 0 carries into minutes.
     - Minutes at MAX_MIN rolls to 00 and pulses wrap.
  3. ADJ_MIN with p2: increment minutes only, MAX_MIN -> 00. No carry and no wrap pulse.
  4. ADJ_SEC with p2: increment seconds only, 59 -> 00. No carry into minutes and no wrap pulse.
- p1 outside RUN is dropped, not deferred. p2 in RUN is ignored.
- Ticks are evaluated against the state register value held before the edge. A mode change and a tick in the same cycle therefore use the old mode.
- Minutes arithmetic is BCD: ones 9 -> 0 carries into tens. MAX_MIN is compared as a decimal value against the digit pair (tens\*10 + ones).

## Timing
- Reset values: all digits 0, mode 00 (RUN), wrap 0.
- t1_q and t2_q reset to 1, so a strobe held high across reset release is not counted.
- Latency: if p1 or p2 is true at edge k, the new digits are visible immediately after edge k. All outputs are registered.
- wrap is high for exactly the one cycle after the rollover edge.
- Reset asserted mid-count clears everything asynchronously. The first count after release needs a fresh rising edge of the strobe.
- A strobe held high for N cycles produces exactly one increment.

## Configuration
- STOPWATCH_SATURATE_EN defined:
  - RUN counting holds at MAX_MIN:59; further p1 pulses are ignored.
  - wrap is tied to 0.
  - Adjust-mode wrapping is unchanged.
- STOPWATCH_SATURATE_EN undefined: RUN counting rolls over to 00:00 and pulses wrap, as described in Operation.

## Test plan
- Reset, then three tick_1_in pulses, each held high for 200 cycles -> count reads 00:03, mode=00.
- Preload 00:59 via ADJ_SEC, return to RUN, one tick_1_in pulse -> 01:00 and wrap stays 0.
- Preload MAX_MIN:59 (59:59), one tick_1_in pulse -> 00:00 and wrap=1 for one cycle. With STOPWATCH_SATURATE_EN: holds 59:59 and wrap=0.
- Set adj=1, sel=0; apply 61 tick_2_in pulses from 00:00 -> 01:00 with no seconds change. Simultaneous tick_1_in pulses are ignored.
- clr asserted in the same cycle as a p1 edge at 12:34 -> 00:00. Deassert clr and apply one tick_1_in pulse -> 00:01.
- Hold tick_1_in high through rst_n deassertion -> no increment. The next genuine rising edge -> 00:01.

Source files
------------

// File: rtl/stopwatch_if.sv
// Signal bundle between the stopwatch core and its surroundings: divider strobes,
// user controls in, BCD display digits and status out.
interface stopwatch_if;
  logic       tick_1_in;
  logic       tick_2_in;
  logic       adj;
  logic       sel;
  logic       clr;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] mode;
  logic       wrap;

  modport master (
    output tick_1_in, tick_2_in, adj, sel, clr,
    input  min_tens, min_ones, sec_tens, sec_ones, mode, wrap
  );

  modport slave (
    input  tick_1_in, tick_2_in, adj, sel, clr,
    output min_tens, min_ones, sec_tens, sec_ones, mode, wrap
  );
endinterface

// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch driven by 1 Hz / 2 Hz divider strobes, with a manual adjust mode.
// Optional macro STOPWATCH_SATURATE_EN: RUN counting holds at MAX_MIN:59 and wrap stays 0.
module stopwatch_counter #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        rst_n,
  stopwatch_if.slave  sw
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_ADJ_MIN = 2'b01,
    ST_ADJ_SEC = 2'b10
  } state_t;

  state_t     state_r, state_s;
  logic       t1_r, t2_r;
  logic       p1_s, p2_s;
  logic [3:0] min_tens_r, min_ones_r, sec_tens_r, sec_ones_r;
  logic [3:0] min_tens_s, min_ones_s, sec_tens_s, sec_ones_s;
  logic       wrap_r, wrap_s;
  logic [6:0] min_val_s;
  logic       sec_max_s, min_max_s;

  // Seconds step 00..59; returns {tens, ones}.
  function automatic logic [7:0] inc_sec(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] r;
    if (o == 4'd9) begin
      if (t == 4'd5) r = 8'h00;
      else           r = {t + 4'd1, 4'd0};
    end else begin
      r = {t, o + 4'd1};
    end
    return r;
  endfunction

  // Minutes step with rollover to 00 once the pair reaches MAX_MIN.
  function automatic logic [7:0] inc_min(input logic [3:0] t, input logic [3:0] o,
                                         input logic at_max);
    logic [7:0] r;
    if (at_max)          r = 8'h00;
    else if (o == 4'd9)  r = {t + 4'd1, 4'd0};
    else                 r = {t, o + 4'd1};
    return r;
  endfunction

  assign p1_s      = sw.tick_1_in & ~t1_r;
  assign p2_s      = sw.tick_2_in & ~t2_r;
  assign min_val_s = 7'(min_tens_r) * 7'd10 + 7'(min_ones_r);
  assign sec_max_s = (sec_tens_r == 4'd5) && (sec_ones_r == 4'd9);
  assign min_max_s = (min_val_s == 7'(MAX_MIN));

  // Mode follows adj/sel directly every cycle.
  always_comb begin
    state_s = ST_RUN;
    if (!sw.adj)     state_s = ST_RUN;
    else if (sw.sel) state_s = ST_ADJ_SEC;
    else             state_s = ST_ADJ_MIN;
  end

  // Next digit values; ticks act on the mode held before this edge.
  always_comb begin
    min_tens_s = min_tens_r;
    min_ones_s = min_ones_r;
    sec_tens_s = sec_tens_r;
    sec_ones_s = sec_ones_r;
    wrap_s     = 1'b0;
    if (sw.clr) begin
      min_tens_s = 4'd0;
      min_ones_s = 4'd0;
      sec_tens_s = 4'd0;
      sec_ones_s = 4'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
`ifdef STOPWATCH_SATURATE_EN
          if (p1_s && !(sec_max_s && min_max_s)) begin
            {sec_tens_s, sec_ones_s} = inc_sec(sec_tens_r, sec_ones_r);
            if (sec_max_s) begin
              {min_tens_s, min_ones_s} = inc_min(min_tens_r, min_ones_r, 1'b0);
            end else begin
              min_tens_s = min_tens_r;
            end
          end else begin
            wrap_s = 1'b0;
          end
`else
          if (p1_s) begin
            {sec_tens_s, sec_ones_s} = inc_sec(sec_tens_r, sec_ones_r);
            if (sec_max_s) begin
              {min_tens_s, min_ones_s} = inc_min(min_tens_r, min_ones_r, min_max_s);
              wrap_s = min_max_s;
            end else begin
              min_tens_s = min_tens_r;
            end
          end else begin
            wrap_s = 1'b0;
          end
`endif
        end
        ST_ADJ_MIN: begin
          if (p2_s) {min_tens_s, min_ones_s} = inc_min(min_tens_r, min_ones_r, min_max_s);
          else      wrap_s = 1'b0;
        end
        ST_ADJ_SEC: begin
          if (p2_s) {sec_tens_s, sec_ones_s} = inc_sec(sec_tens_r, sec_ones_r);
          else      wrap_s = 1'b0;
        end
        default: wrap_s = 1'b0;
      endcase
    end
  end

  // State, strobe history and registered outputs; history resets high so a held strobe is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      t1_r       <= 1'b1;
      t2_r       <= 1'b1;
      min_tens_r <= 4'd0;
      min_ones_r <= 4'd0;
      sec_tens_r <= 4'd0;
      sec_ones_r <= 4'd0;
      wrap_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      t1_r       <= sw.tick_1_in;
      t2_r       <= sw.tick_2_in;
      min_tens_r <= min_tens_s;
      min_ones_r <= min_ones_s;
      sec_tens_r <= sec_tens_s;
      sec_ones_r <= sec_ones_s;
      wrap_r     <= wrap_s;
    end
  end

  assign sw.min_tens = min_tens_r;
  assign sw.min_ones = min_ones_r;
  assign sw.sec_tens = sec_tens_r;
  assign sw.sec_ones = sec_ones_r;
  assign sw.mode     = state_r;
  assign sw.wrap     = wrap_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: run counting, carries, rollover, adjust modes,
// clear priority and strobe handling across reset.
module tb_stopwatch_counter;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   wrap_seen;

  stopwatch_if sw_if();

  stopwatch_counter #(.MAX_MIN(59)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] disp();
    return {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones};
  endfunction

  task automatic pulse1(input int hold);
    @(negedge clk) sw_if.tick_1_in = 1'b1;
    repeat (hold) @(negedge clk);
    sw_if.tick_1_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Pulses tick_2_in n times, optionally with tick_1_in rising alongside; counts wrap highs.
  task automatic pulse2(input int n, input logic with_t1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sw_if.tick_2_in = 1'b1;
      sw_if.tick_1_in = with_t1;
      @(negedge clk);
      if (sw_if.wrap) wrap_seen++;
      sw_if.tick_2_in = 1'b0;
      sw_if.tick_1_in = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_mode(input logic a, input logic s);
    @(negedge clk);
    sw_if.adj = a;
    sw_if.sel = s;
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk) sw_if.clr = 1'b1;
    @(negedge clk) sw_if.clr = 1'b0;
  endtask

  task automatic check_disp(input string name, input logic [15:0] exp);
    checks++;
    if (disp() !== exp) begin
      errors++;
      $display("FAIL %s disp=%h expected=%h", name, disp(), exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_if.tick_1_in = 1'b0; sw_if.tick_2_in = 1'b0;
    sw_if.adj = 1'b0; sw_if.sel = 1'b0; sw_if.clr = 1'b0;
    repeat (3) @(negedge clk);
    check_disp("reset_digits", 16'h0000);
    checks++;
    if (sw_if.mode !== 2'b00 || sw_if.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_status mode=%b wrap=%b expected mode=00 wrap=0", sw_if.mode, sw_if.wrap);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_run_count();
    for (int i = 0; i < 3; i++) pulse1(200);
    check_disp("run_three_ticks", 16'h0003);
    checks++;
    if (sw_if.mode !== 2'b00) begin
      errors++;
      $display("FAIL run_mode mode=%b expected=00", sw_if.mode);
    end
    pulse2(4, 1'b0);
    check_disp("p2_ignored_in_run", 16'h0003);
  endtask

  task automatic test_carry();
    do_clear();
    set_mode(1'b1, 1'b1);
    pulse2(59, 1'b0);
    check_disp("preload_0059", 16'h0059);
    set_mode(1'b0, 1'b0);
    @(negedge clk) sw_if.tick_1_in = 1'b1;
    @(negedge clk);
    check_disp("carry_to_0100", 16'h0100);
    checks++;
    if (sw_if.wrap !== 1'b0) begin
      errors++;
      $display("FAIL carry_wrap wrap=%b expected=0", sw_if.wrap);
    end
    sw_if.tick_1_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_disp;
    logic        exp_wrap;
`ifdef STOPWATCH_SATURATE_EN
    exp_disp = 16'h5959;
    exp_wrap = 1'b0;
`else
    exp_disp = 16'h0000;
    exp_wrap = 1'b1;
`endif
    do_clear();
    set_mode(1'b1, 1'b0);
    pulse2(59, 1'b0);
    set_mode(1'b1, 1'b1);
    pulse2(59, 1'b0);
    check_disp("preload_5959", 16'h5959);
    set_mode(1'b0, 1'b0);
    @(negedge clk) sw_if.tick_1_in = 1'b1;
    @(negedge clk);
    check_disp("rollover_digits", exp_disp);
    checks++;
    if (sw_if.wrap !== exp_wrap) begin
      errors++;
      $display("FAIL rollover_wrap wrap=%b expected=%b", sw_if.wrap, exp_wrap);
    end
    @(negedge clk);
    checks++;
    if (sw_if.wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_one_cycle wrap=%b expected=0", sw_if.wrap);
    end
    sw_if.tick_1_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_adj_min();
    do_clear();
    set_mode(1'b1, 1'b0);
    wrap_seen = 0;
    pulse2(61, 1'b1);
    check_disp("adj_min_61", 16'h0100);
    checks++;
    if (sw_if.mode !== 2'b01 || wrap_seen != 0) begin
      errors++;
      $display("FAIL adj_min_status mode=%b wraps=%0d expected mode=01 wraps=0", sw_if.mode, wrap_seen);
    end
  endtask

  task automatic test_adj_sec();
    set_mode(1'b1, 1'b1);
    wrap_seen = 0;
    pulse2(61, 1'b0);
    check_disp("adj_sec_no_carry", 16'h0101);
    checks++;
    if (sw_if.mode !== 2'b10 || wrap_seen != 0) begin
      errors++;
      $display("FAIL adj_sec_status mode=%b wraps=%0d expected mode=10 wraps=0", sw_if.mode, wrap_seen);
    end
  endtask

  task automatic test_clr();
    do_clear();
    set_mode(1'b1, 1'b0);
    pulse2(12, 1'b0);
    set_mode(1'b1, 1'b1);
    pulse2(34, 1'b0);
    set_mode(1'b0, 1'b0);
    check_disp("preload_1234", 16'h1234);
    @(negedge clk);
    sw_if.tick_1_in = 1'b1;
    sw_if.clr = 1'b1;
    @(negedge clk);
    check_disp("clr_beats_tick", 16'h0000);
    sw_if.clr = 1'b0;
    sw_if.tick_1_in = 1'b0;
    pulse1(3);
    check_disp("after_clr_tick", 16'h0001);
  endtask

  task automatic test_reset_held();
    @(negedge clk) sw_if.tick_1_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_disp("held_tick_across_reset", 16'h0000);
    sw_if.tick_1_in = 1'b0;
    @(negedge clk);
    pulse1(10);
    check_disp("first_edge_after_reset", 16'h0001);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    wrap_seen = 0;
    test_reset();
    test_run_count();
    test_carry();
    test_wrap();
    test_adj_min();
    test_adj_sec();
    test_clr();
    test_reset_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
